// File: rtl/sdram_burst_master_if.sv
// Host and SDRAM-controller signal bundle for sdram_burst_master.
// The master modport is the burst master's view; slave is the environment's view.
interface sdram_burst_master_if #(
   parameter int ASIZE = 22,
   parameter int DSIZE = 16
);
   // host side
   logic             H_REQ;
   logic             H_WE;
   logic [ASIZE-1:0] H_ADDR;
   logic [3:0]       H_LEN;
   logic [DSIZE-1:0] H_WDATA;
   logic             H_WVALID;
   logic             H_BUSY;
   logic [DSIZE-1:0] H_RDATA;
   logic             H_RVALID;
   logic             H_DONE;
   logic             H_ERR;
   // controller side
   logic [ASIZE-1:0]   ADDR;
   logic               WR;
   logic               RD;
   logic [7:0]         LENGTH;
   logic [DSIZE-1:0]   DATAIN;
   logic [DSIZE/8-1:0] DM;
   logic               ACT;
   logic               DONE;
   logic               IN_REQ;
   logic               OUT_VALID;
   logic [DSIZE-1:0]   DATAOUT;

   modport master (
      input  H_REQ, H_WE, H_ADDR, H_LEN, H_WDATA, H_WVALID,
      output H_BUSY, H_RDATA, H_RVALID, H_DONE, H_ERR,
      output ADDR, WR, RD, LENGTH, DATAIN, DM,
      input  ACT, DONE, IN_REQ, OUT_VALID, DATAOUT
   );

   modport slave (
      output H_REQ, H_WE, H_ADDR, H_LEN, H_WDATA, H_WVALID,
      input  H_BUSY, H_RDATA, H_RVALID, H_DONE, H_ERR,
      input  ADDR, WR, RD, LENGTH, DATAIN, DM,
      output ACT, DONE, IN_REQ, OUT_VALID, DATAOUT
   );
endinterface

// File: rtl/sdram_burst_master.sv
// Burst master between a simple host port and an SDRAM controller.
// Writes are staged in an 8-word buffer before WR is raised; reads stream
// controller data back to the host. A watchdog aborts bursts lacking DONE.
module sdram_burst_master #(
   parameter int ASIZE = 22,
   parameter int DSIZE = 16,
   parameter int TMO   = 255
) (
   input logic CLK,
   input logic RESET,
   sdram_burst_master_if.master bus
);

   localparam int TW = (TMO < 2) ? 1 : $clog2(TMO + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WREQ,
      S_RREQ,
      S_GAP
   } state_t;

   state_t           state;
   logic [ASIZE-1:0] addr_q;
   logic [3:0]       len_q;
   logic [3:0]       len_in;
   logic [3:0]       wcnt;
   logic [3:0]       wcnt_nxt;
   logic [3:0]       rptr;
   logic [3:0]       rcnt;
   logic [TW-1:0]    tmo_cnt;
   logic             wr_q;
   logic             rd_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic             rvalid_q;
   logic [DSIZE-1:0] rdata_q;
   logic             ov_d;
   logic             rd_mode;

   logic [DSIZE-1:0] wbuf [8];
   logic             buf_we;
   logic [2:0]       buf_wa;
   logic [2:0]       rd_idx;
   logic [2:0]       last_idx;

   // Clamp the requested length into 1..8.
   always_comb begin
      if (bus.H_LEN == 4'd0)
         len_in = 4'd1;
      else if (bus.H_LEN > 4'd8)
         len_in = 4'd8;
      else
         len_in = bus.H_LEN;
   end

   // Write-buffer port: word 0 may arrive with the request itself.
   always_comb begin
      buf_we = 1'b0;
      buf_wa = '0;
      if (state == S_IDLE && bus.H_REQ && bus.H_WE && bus.H_WVALID) begin
         buf_we = 1'b1;
         buf_wa = '0;
      end else if (state == S_LOAD && bus.H_WVALID && wcnt < len_q) begin
         buf_we = 1'b1;
         buf_wa = wcnt[2:0];
      end
      wcnt_nxt = wcnt + {3'b000, buf_we};
   end

   // Write-data storage; contents are don't-care until loaded.
   always_ff @(posedge CLK) begin
      if (buf_we)
         wbuf[buf_wa] <= bus.H_WDATA;
   end

   // Read-out index: once the pointer saturates, keep showing the last word.
   always_comb begin
      last_idx = 3'(len_q - 4'd1);
      rd_idx   = (rptr < len_q) ? rptr[2:0] : last_idx;
   end

   assign bus.DATAIN   = wbuf[rd_idx];
   assign bus.DM       = (state == S_WREQ && rptr >= len_q) ? '1 : '0;
   assign bus.ADDR     = addr_q;
   assign bus.LENGTH   = {4'b0000, len_q};
   assign bus.WR       = wr_q;
   assign bus.RD       = rd_q;
   assign bus.H_BUSY   = busy_q;
   assign bus.H_DONE   = done_q;
   assign bus.H_ERR    = err_q;
   assign bus.H_RVALID = rvalid_q;
   assign bus.H_RDATA  = rdata_q;

   // Control FSM with registered controller/host outputs and read capture.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= S_IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         wcnt     <= '0;
         rptr     <= '0;
         rcnt     <= '0;
         tmo_cnt  <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         ov_d     <= 1'b0;
         rd_mode  <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rvalid_q <= 1'b0;

         // OUT_VALID leads the matching DATAOUT word by one cycle, so the
         // word is taken on the cycle after OUT_VALID.
         ov_d <= bus.OUT_VALID;
         if (ov_d && rd_mode && rcnt < len_q) begin
            rdata_q  <= bus.DATAOUT;
            rvalid_q <= 1'b1;
            rcnt     <= rcnt + 4'd1;
         end

         case (state)
            S_IDLE: begin
               if (bus.H_REQ) begin
                  addr_q  <= bus.H_ADDR;
                  len_q   <= len_in;
                  tmo_cnt <= '0;
                  busy_q  <= 1'b1;
                  if (bus.H_WE) begin
                     state   <= S_LOAD;
                     rd_mode <= 1'b0;
                     wcnt    <= {3'b000, bus.H_WVALID};
                  end else begin
                     state   <= S_RREQ;
                     rd_q    <= 1'b1;
                     rd_mode <= 1'b1;
                     rcnt    <= '0;
                  end
               end
            end

            S_LOAD: begin
               wcnt <= wcnt_nxt;
               // Leaving on the push that fills the burst lets WR rise
               // one cycle after the final word.
               if (wcnt_nxt >= len_q) begin
                  state   <= S_WREQ;
                  wr_q    <= 1'b1;
                  rptr    <= '0;
                  tmo_cnt <= '0;
               end
            end

            S_WREQ, S_RREQ: begin
               if (state == S_WREQ && bus.IN_REQ && rptr < len_q)
                  rptr <= rptr + 4'd1;
               if (bus.DONE) begin
                  state  <= S_GAP;
                  wr_q   <= 1'b0;
                  rd_q   <= 1'b0;
                  done_q <= 1'b1;
               end else if (tmo_cnt == TMO_LAST) begin
                  state <= S_GAP;
                  wr_q  <= 1'b0;
                  rd_q  <= 1'b0;
                  err_q <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end

            S_GAP: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end

            default: begin
               state  <= S_IDLE;
               wr_q   <= 1'b0;
               rd_q   <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_burst_master.sv
// Self-checking bench for sdram_burst_master: a table of single-burst
// vectors plus hand-written sequences for the multi-cycle corner cases.
module tb_sdram_burst_master;

   logic CLK = 1'b0;
   logic RESET;
   int   n_checks = 0;
   int   n_fail   = 0;

   sdram_burst_master_if #(.ASIZE(22), .DSIZE(16)) bus ();

   sdram_burst_master #(.ASIZE(22), .DSIZE(16), .TMO(255)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        we;
      logic [3:0]  len;
      logic [21:0] addr;
      logic [7:0]  exp_len;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] wword(input int v, input int i);
      return 16'(32'hA000 + v * 16 + i);
   endfunction

   // Controller read stream: OUT_VALID for n cycles, each word on DATAOUT one
   // cycle later; expect exp_n host words, each two cycles after OUT_VALID.
   task automatic read_stream(input int n, input int exp_n, input logic [15:0] base);
      logic exp_v;
      for (int k = 0; k < n + 4; k++) begin
         bus.OUT_VALID = (k < n);
         bus.DATAOUT   = (k >= 1 && k <= n) ? base + 16'(k - 1) : 16'h0000;
         tick();
         exp_v = (k >= 1 && k <= exp_n);
         chk("h_rvalid", {31'd0, bus.H_RVALID}, {31'd0, exp_v});
         if (exp_v)
            chk("h_rdata", {16'd0, bus.H_RDATA}, {16'd0, base + 16'(k - 1)});
      end
      bus.OUT_VALID = 1'b0;
      bus.DATAOUT   = '0;
   endtask

   task automatic finish_ok(input string nm);
      bus.DONE = 1'b1;
      tick();
      bus.DONE   = 1'b0;
      bus.IN_REQ = 1'b0;
      chk({nm, "_wr_low"}, {31'd0, bus.WR}, 32'd0);
      chk({nm, "_rd_low"}, {31'd0, bus.RD}, 32'd0);
      chk({nm, "_h_done"}, {31'd0, bus.H_DONE}, 32'd1);
      chk({nm, "_h_err"},  {31'd0, bus.H_ERR}, 32'd0);
      tick();
      chk({nm, "_idle_busy"}, {31'd0, bus.H_BUSY}, 32'd0);
      chk({nm, "_done_clr"},  {31'd0, bus.H_DONE}, 32'd0);
   endtask

   task automatic run_vec(input int v);
      int n;
      n = int'(vecs[v].exp_len);
      bus.H_REQ  = 1'b1;
      bus.H_WE   = vecs[v].we;
      bus.H_ADDR = vecs[v].addr;
      bus.H_LEN  = vecs[v].len;
      if (vecs[v].we) begin
         bus.H_WVALID = 1'b1;
         bus.H_WDATA  = wword(v, 0);
         tick();
         bus.H_REQ = 1'b0;
         for (int i = 1; i < n; i++) begin
            bus.H_WDATA = wword(v, i);
            tick();
         end
         bus.H_WVALID = 1'b0;
         if (n == 1)
            tick();
         chk("vec_wr", {31'd0, bus.WR}, 32'd1);
         chk("vec_rd", {31'd0, bus.RD}, 32'd0);
      end else begin
         tick();
         bus.H_REQ = 1'b0;
         chk("vec_rd", {31'd0, bus.RD}, 32'd1);
         chk("vec_wr", {31'd0, bus.WR}, 32'd0);
      end
      chk("vec_length", {24'd0, bus.LENGTH}, {24'd0, vecs[v].exp_len});
      chk("vec_addr", {10'd0, bus.ADDR}, {10'd0, vecs[v].addr});
      chk("vec_busy", {31'd0, bus.H_BUSY}, 32'd1);
      if (vecs[v].we) begin
         for (int i = 0; i < n; i++) begin
            bus.IN_REQ = 1'b1;
            chk("vec_datain", {16'd0, bus.DATAIN}, {16'd0, wword(v, i)});
            chk("vec_dm", {30'd0, bus.DM}, 32'd0);
            tick();
         end
         bus.IN_REQ = 1'b0;
      end
      finish_ok("vec");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

   initial begin
      int rd_cycles;
      int errs;
      int dones;
      logic prev_rd;

      vecs[0] = '{1'b0, 4'd0,  22'h000100, 8'd1};
      vecs[1] = '{1'b1, 4'd0,  22'h000200, 8'd1};
      vecs[2] = '{1'b0, 4'd15, 22'h000300, 8'd8};
      vecs[3] = '{1'b1, 4'd15, 22'h000400, 8'd8};
      vecs[4] = '{1'b1, 4'd3,  22'h3FFFFF, 8'd3};
      vecs[5] = '{1'b0, 4'd9,  22'h155555, 8'd8};
      vecs[6] = '{1'b1, 4'd8,  22'h2AAAAA, 8'd8};
      vecs[7] = '{1'b0, 4'd1,  22'h000001, 8'd1};

      RESET         = 1'b1;
      bus.H_REQ     = 1'b0;
      bus.H_WE      = 1'b0;
      bus.H_ADDR    = '0;
      bus.H_LEN     = '0;
      bus.H_WDATA   = '0;
      bus.H_WVALID  = 1'b0;
      bus.ACT       = 1'b0;
      bus.DONE      = 1'b0;
      bus.IN_REQ    = 1'b0;
      bus.OUT_VALID = 1'b0;
      bus.DATAOUT   = '0;

      // reset state
      tick();
      tick();
      chk("rst_wr",     {31'd0, bus.WR}, 32'd0);
      chk("rst_rd",     {31'd0, bus.RD}, 32'd0);
      chk("rst_busy",   {31'd0, bus.H_BUSY}, 32'd0);
      chk("rst_done",   {31'd0, bus.H_DONE}, 32'd0);
      chk("rst_err",    {31'd0, bus.H_ERR}, 32'd0);
      chk("rst_rvalid", {31'd0, bus.H_RVALID}, 32'd0);
      chk("rst_addr",   {10'd0, bus.ADDR}, 32'd0);
      chk("rst_length", {24'd0, bus.LENGTH}, 32'd0);
      chk("rst_rdata",  {16'd0, bus.H_RDATA}, 32'd0);
      chk("rst_dm",     {30'd0, bus.DM}, 32'd0);
      RESET = 1'b0;
      tick();

      // write LEN=4, words A0..A3
      bus.H_REQ    = 1'b1;
      bus.H_WE     = 1'b1;
      bus.H_ADDR   = 22'h001234;
      bus.H_LEN    = 4'd4;
      bus.H_WVALID = 1'b1;
      bus.H_WDATA  = 16'h00A0;
      tick();
      bus.H_REQ = 1'b0;
      for (int i = 1; i < 4; i++) begin
         bus.H_WDATA = 16'(16'h00A0 + i);
         chk("w4_wr_before_last", {31'd0, bus.WR}, 32'd0);
         tick();
      end
      bus.H_WVALID = 1'b0;
      chk("w4_wr_rise", {31'd0, bus.WR}, 32'd1);
      chk("w4_length",  {24'd0, bus.LENGTH}, 32'd4);
      chk("w4_addr",    {10'd0, bus.ADDR}, 32'h001234);
      for (int i = 0; i < 4; i++) begin
         bus.IN_REQ = 1'b1;
         chk("w4_datain", {16'd0, bus.DATAIN}, 32'(16'h00A0 + i));
         chk("w4_dm", {30'd0, bus.DM}, 32'd0);
         tick();
      end
      bus.IN_REQ = 1'b0;
      finish_ok("w4");

      // read LEN=8, 9 words offered, 9th dropped; ACT has no effect
      bus.ACT    = 1'b1;
      bus.H_REQ  = 1'b1;
      bus.H_WE   = 1'b0;
      bus.H_ADDR = 22'h00ABCD;
      bus.H_LEN  = 4'd8;
      tick();
      bus.H_REQ = 1'b0;
      chk("r8_rd", {31'd0, bus.RD}, 32'd1);
      chk("r8_wr", {31'd0, bus.WR}, 32'd0);
      chk("r8_length", {24'd0, bus.LENGTH}, 32'd8);
      read_stream(9, 8, 16'hD000);
      chk("r8_rd_held", {31'd0, bus.RD}, 32'd1);
      bus.ACT = 1'b0;
      finish_ok("r8");

      // table of single bursts
      for (int v = 0; v < 8; v++)
         run_vec(v);

      // write LEN=4 with 6 IN_REQ cycles; stray pushes during WREQ ignored
      bus.H_REQ    = 1'b1;
      bus.H_WE     = 1'b1;
      bus.H_ADDR   = 22'h005000;
      bus.H_LEN    = 4'd4;
      bus.H_WVALID = 1'b1;
      bus.H_WDATA  = 16'hB000;
      tick();
      bus.H_REQ = 1'b0;
      for (int i = 1; i < 4; i++) begin
         bus.H_WDATA = 16'(16'hB000 + i);
         tick();
      end
      bus.H_WDATA = 16'hBAD0;
      chk("ovr_wr", {31'd0, bus.WR}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         bus.IN_REQ = 1'b1;
         chk("ovr_datain", {16'd0, bus.DATAIN}, 32'(16'hB000 + ((i < 4) ? i : 3)));
         chk("ovr_dm", {30'd0, bus.DM}, (i < 4) ? 32'd0 : 32'd3);
         tick();
      end
      bus.H_WVALID = 1'b0;
      finish_ok("ovr");

      // watchdog: DONE never arrives
      bus.H_REQ  = 1'b1;
      bus.H_WE   = 1'b0;
      bus.H_ADDR = 22'h006000;
      bus.H_LEN  = 4'd2;
      tick();
      bus.H_REQ = 1'b0;
      rd_cycles = 0;
      errs      = 0;
      dones     = 0;
      prev_rd   = 1'b0;
      for (int i = 0; i < 270; i++) begin
         if (bus.RD) rd_cycles++;
         if (bus.H_ERR) errs++;
         if (bus.H_DONE) dones++;
         if (prev_rd && !bus.RD)
            chk("wd_err_on_drop", {31'd0, bus.H_ERR}, 32'd1);
         prev_rd = bus.RD;
         tick();
      end
      chk("wd_rd_cycles", 32'(rd_cycles), 32'd255);
      chk("wd_err_pulses", 32'(errs), 32'd1);
      chk("wd_done_pulses", 32'(dones), 32'd0);
      chk("wd_busy", {31'd0, bus.H_BUSY}, 32'd0);

      // DONE on the expiry cycle counts as success
      bus.H_REQ  = 1'b1;
      bus.H_WE   = 1'b0;
      bus.H_ADDR = 22'h007000;
      bus.H_LEN  = 4'd1;
      tick();
      bus.H_REQ = 1'b0;
      repeat (254) tick();
      chk("edge_rd_still", {31'd0, bus.RD}, 32'd1);
      finish_ok("edge");

      // back-to-back write then read with H_REQ held
      bus.H_REQ    = 1'b1;
      bus.H_WE     = 1'b1;
      bus.H_ADDR   = 22'h002000;
      bus.H_LEN    = 4'd1;
      bus.H_WVALID = 1'b1;
      bus.H_WDATA  = 16'h5A5A;
      tick();
      bus.H_WE     = 1'b0;
      bus.H_ADDR   = 22'h003000;
      bus.H_LEN    = 4'd2;
      bus.H_WVALID = 1'b0;
      chk("b2b_load_wr", {31'd0, bus.WR}, 32'd0);
      tick();
      chk("b2b_wr", {31'd0, bus.WR}, 32'd1);
      chk("b2b_rd_off", {31'd0, bus.RD}, 32'd0);
      chk("b2b_addr_kept", {10'd0, bus.ADDR}, 32'h002000);
      bus.IN_REQ = 1'b1;
      chk("b2b_datain", {16'd0, bus.DATAIN}, 32'h5A5A);
      bus.DONE = 1'b1;
      tick();
      bus.DONE   = 1'b0;
      bus.IN_REQ = 1'b0;
      chk("b2b_gap_wr", {31'd0, bus.WR}, 32'd0);
      chk("b2b_gap_rd", {31'd0, bus.RD}, 32'd0);
      chk("b2b_gap_done", {31'd0, bus.H_DONE}, 32'd1);
      tick();
      chk("b2b_idle_rd", {31'd0, bus.RD}, 32'd0);
      chk("b2b_idle_busy", {31'd0, bus.H_BUSY}, 32'd0);
      tick();
      bus.H_REQ = 1'b0;
      chk("b2b_rd", {31'd0, bus.RD}, 32'd1);
      chk("b2b_wr_off", {31'd0, bus.WR}, 32'd0);
      chk("b2b_addr2", {10'd0, bus.ADDR}, 32'h003000);
      chk("b2b_len2", {24'd0, bus.LENGTH}, 32'd2);
      read_stream(2, 2, 16'hE000);
      finish_ok("b2b");

      // reset asserted mid-write
      bus.H_REQ    = 1'b1;
      bus.H_WE     = 1'b1;
      bus.H_ADDR   = 22'h004000;
      bus.H_LEN    = 4'd2;
      bus.H_WVALID = 1'b1;
      bus.H_WDATA  = 16'h1111;
      tick();
      bus.H_REQ   = 1'b0;
      bus.H_WDATA = 16'h2222;
      tick();
      bus.H_WVALID = 1'b0;
      chk("mrst_wr_before", {31'd0, bus.WR}, 32'd1);
      #2;
      RESET = 1'b1;
      #1;
      chk("mrst_wr", {31'd0, bus.WR}, 32'd0);
      chk("mrst_busy", {31'd0, bus.H_BUSY}, 32'd0);
      tick();
      RESET = 1'b0;
      tick();
      bus.H_REQ  = 1'b1;
      bus.H_WE   = 1'b0;
      bus.H_ADDR = 22'h008000;
      bus.H_LEN  = 4'd2;
      tick();
      bus.H_REQ = 1'b0;
      chk("mrst_rd", {31'd0, bus.RD}, 32'd1);
      read_stream(2, 2, 16'hF000);
      finish_ok("mrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
